// File: rtl/multicycle_control_unit_pkg.sv
// multicycle_control_unit_pkg
// Shared definitions for the multi-cycle CPU control unit: opcode and func
// constants, FSM state encoding, ALU op codes, datapath mux encodings,
// instruction classes and the packed control-word struct.
// No ports (package).

package multicycle_control_unit_pkg;

   localparam int WORD_SIZE = 16;

   // opcodes, instruction[WORD_SIZE-1 -: 4]
   localparam logic [3:0] OP_BNE   = 4'h0;
   localparam logic [3:0] OP_BEQ   = 4'h1;
   localparam logic [3:0] OP_BGZ   = 4'h2;
   localparam logic [3:0] OP_BLZ   = 4'h3;
   localparam logic [3:0] OP_ADI   = 4'h4;
   localparam logic [3:0] OP_ORI   = 4'h5;
   localparam logic [3:0] OP_LHI   = 4'h6;
   localparam logic [3:0] OP_LWD   = 4'h7;
   localparam logic [3:0] OP_SWD   = 4'h8;
   localparam logic [3:0] OP_JMP   = 4'h9;
   localparam logic [3:0] OP_JAL   = 4'hA;
   localparam logic [3:0] OP_RTYPE = 4'hF;

   // func field, instruction[5:0], opcode OP_RTYPE only
   localparam logic [5:0] FN_ADD = 6'd0;
   localparam logic [5:0] FN_SUB = 6'd1;
   localparam logic [5:0] FN_AND = 6'd2;
   localparam logic [5:0] FN_ORR = 6'd3;
   localparam logic [5:0] FN_NOT = 6'd4;
   localparam logic [5:0] FN_TCP = 6'd5;
   localparam logic [5:0] FN_SHL = 6'd6;
   localparam logic [5:0] FN_SHR = 6'd7;
   localparam logic [5:0] FN_JPR = 6'd25;
   localparam logic [5:0] FN_JRL = 6'd26;
   localparam logic [5:0] FN_WWD = 6'd28;
   localparam logic [5:0] FN_HLT = 6'd29;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h5;
   localparam logic [3:0] ALU_ORR = 4'h6;
   localparam logic [3:0] ALU_NOT = 4'h9;
   localparam logic [3:0] ALU_SHR = 4'hA;
   localparam logic [3:0] ALU_TCP = 4'hC;
   localparam logic [3:0] ALU_SHL = 4'hD;
   localparam logic [3:0] ALU_LHI = 4'hF;

   localparam logic [1:0] RD_RT   = 2'd0;
   localparam logic [1:0] RD_RD   = 2'd1;
   localparam logic [1:0] RD_LINK = 2'd2;

   localparam logic [1:0] MR_ALU = 2'd0;
   localparam logic [1:0] MR_MDR = 2'd1;
   localparam logic [1:0] MR_PC1 = 2'd2;

   localparam logic [1:0] PS_PC1    = 2'd0;
   localparam logic [1:0] PS_ALUOUT = 2'd1;
   localparam logic [1:0] PS_JUMP   = 2'd2;
   localparam logic [1:0] PS_REG    = 2'd3;

   localparam logic [1:0] SB_REG = 2'd0;
   localparam logic [1:0] SB_ONE = 2'd1;
   localparam logic [1:0] SB_IMM = 2'd2;

   typedef enum logic [3:0] {
      IC_RTYPE,
      IC_ITYPE,
      IC_LOAD,
      IC_STORE,
      IC_BRANCH,
      IC_JUMP,
      IC_JREG,
      IC_WWD,
      IC_HALT,
      IC_ILLEGAL
   } iclass_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [3:0] alu_op;
      logic [1:0] branch_type;
      logic       wwd_valid;
      logic       halted;
      logic       illegal;
   } ctl_t;

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// mcu_decode
// Combinational instruction classifier and ALU op lookup.
// Ports:
//   opcode  in  4  instruction opcode field
//   func    in  6  R-type function field
//   iclass  out    instruction class
//   link    out 1  instruction also writes the return address to $2
//   alu_op  out 4  ALU function used in EX

module mcu_decode
   import multicycle_control_unit_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [5:0] func,
   output iclass_t    iclass,
   output logic       link,
   output logic [3:0] alu_op
);

   always_comb begin
      iclass = IC_ILLEGAL;
      link   = 1'b0;
      alu_op = ALU_ADD;
      case (opcode)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: begin
            iclass = IC_BRANCH;
            alu_op = ALU_SUB;
         end
         OP_ADI:   iclass = IC_ITYPE;
         OP_ORI: begin
            iclass = IC_ITYPE;
            alu_op = ALU_ORR;
         end
         OP_LHI: begin
            iclass = IC_ITYPE;
            alu_op = ALU_LHI;
         end
         OP_LWD:   iclass = IC_LOAD;
         OP_SWD:   iclass = IC_STORE;
         OP_JMP:   iclass = IC_JUMP;
         OP_JAL: begin
            iclass = IC_JUMP;
            link   = 1'b1;
         end
         OP_RTYPE: begin
            iclass = IC_RTYPE;
            case (func)
               FN_ADD: alu_op = ALU_ADD;
               FN_SUB: alu_op = ALU_SUB;
               FN_AND: alu_op = ALU_AND;
               FN_ORR: alu_op = ALU_ORR;
               FN_NOT: alu_op = ALU_NOT;
               FN_TCP: alu_op = ALU_TCP;
               FN_SHL: alu_op = ALU_SHL;
               FN_SHR: alu_op = ALU_SHR;
               FN_JPR: iclass = IC_JREG;
               FN_JRL: begin
                  iclass = IC_JREG;
                  link   = 1'b1;
               end
               FN_WWD: iclass = IC_WWD;
               FN_HLT: iclass = IC_HALT;
               default: iclass = IC_ILLEGAL;
            endcase
         end
         default: iclass = IC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Multi-cycle sequencing FSM for the 16-bit CPU datapath. Steps each
// instruction through fetch/decode/execute/memory/write-back and drives the
// datapath enables and mux selects.
// Optional feature: define MCU_PERF_CNT_EN to add the retired-instruction
// counter and its num_inst port.
// Ports:
//   clk, reset_n (async, active-low)
//   instruction      in  IR contents, decoded from ID onward
//   mem_ready        in  memory completed the current request
//   pc_write .. reg_write, reg_dst, mem_to_reg, alu_src_a/b, pc_source,
//   alu_op, branch_type  out  datapath controls
//   wwd_valid, halted, illegal  out  status
//   num_inst         out  retired count (MCU_PERF_CNT_EN only)
//
// state | meaning
// IF    | fetch: mem_read until mem_ready, then latch IR and PC+1
// ID    | decode; jumps, WWD, illegal and HLT finish here
// EX    | ALU op, address add, or branch compare
// MEM   | data access until mem_ready
// WB    | register file write
// HALT  | parked after HLT until reset

module multicycle_control_unit #(
   parameter int WORD_SIZE = multicycle_control_unit_pkg::WORD_SIZE
`ifdef MCU_PERF_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] instruction,
   input  logic                 mem_ready,
   output logic                 pc_write,
   output logic                 pc_write_cond,
   output logic                 ir_write,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 reg_write,
   output logic [1:0]           reg_dst,
   output logic [1:0]           mem_to_reg,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           pc_source,
   output logic [3:0]           alu_op,
   output logic [1:0]           branch_type,
   output logic                 wwd_valid,
   output logic                 halted,
   output logic                 illegal
`ifdef MCU_PERF_CNT_EN
   , output logic [CNT_W-1:0]   num_inst
`endif
);

   import multicycle_control_unit_pkg::*;

   state_t     state_q, state_d;
   iclass_t    iclass;
   logic       link;
   logic [3:0] dec_alu_op;
   logic [3:0] opcode;
   logic [5:0] func;
   ctl_t       ctl, ctl_out;
   logic       unused_ir;

   assign opcode    = instruction[WORD_SIZE-1 -: 4];
   assign func      = instruction[5:0];
   assign unused_ir = ^instruction[WORD_SIZE-5:6];

   mcu_decode u_decode (
      .opcode (opcode),
      .func   (func),
      .iclass (iclass),
      .link   (link),
      .alu_op (dec_alu_op)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IF;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:  if (mem_ready) state_d = S_ID;
         S_ID: begin
            case (iclass)
               IC_JUMP, IC_JREG, IC_WWD, IC_ILLEGAL: state_d = S_IF;
               IC_HALT: state_d = S_HALT;
               default: state_d = S_EX;
            endcase
         end
         S_EX: begin
            case (iclass)
               IC_RTYPE, IC_ITYPE: state_d = S_WB;
               IC_LOAD, IC_STORE:  state_d = S_MEM;
               default:            state_d = S_IF;
            endcase
         end
         S_MEM: if (mem_ready) state_d = (iclass == IC_LOAD) ? S_WB : S_IF;
         S_WB:   state_d = S_IF;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   always_comb begin
      ctl = '0;
      case (state_q)
         S_IF: begin
            ctl.mem_read  = 1'b1;
            ctl.alu_src_b = SB_ONE;
            // IR and PC+1 are latched in the cycle the fetch completes
            if (mem_ready) begin
               ctl.ir_write = 1'b1;
               ctl.pc_write = 1'b1;
            end
         end
         S_ID: begin
            // ALUOut <= PC+1+imm, the branch target consumed in EX
            ctl.alu_src_b = SB_IMM;
            case (iclass)
               IC_JUMP, IC_JREG: begin
                  ctl.pc_write  = 1'b1;
                  ctl.pc_source = (iclass == IC_JUMP) ? PS_JUMP : PS_REG;
                  if (link) begin
                     ctl.reg_write  = 1'b1;
                     ctl.reg_dst    = RD_LINK;
                     ctl.mem_to_reg = MR_PC1;
                  end
               end
               IC_WWD:     ctl.wwd_valid = 1'b1;
               IC_ILLEGAL: ctl.illegal   = 1'b1;
               default: ;
            endcase
         end
         S_EX: begin
            ctl.alu_src_a = 1'b1;
            ctl.alu_op    = dec_alu_op;
            case (iclass)
               IC_ITYPE, IC_LOAD, IC_STORE: ctl.alu_src_b = SB_IMM;
               IC_BRANCH: begin
                  ctl.pc_write_cond = 1'b1;
                  ctl.pc_source     = PS_ALUOUT;
                  ctl.branch_type   = opcode[1:0];
               end
               default: ctl.alu_src_b = SB_REG;
            endcase
         end
         S_MEM: begin
            ctl.i_or_d    = 1'b1;
            ctl.mem_read  = (iclass == IC_LOAD);
            ctl.mem_write = (iclass == IC_STORE);
         end
         S_WB: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = (iclass == IC_RTYPE) ? RD_RD : RD_RT;
            ctl.mem_to_reg = (iclass == IC_LOAD) ? MR_MDR : MR_ALU;
         end
         S_HALT: ctl.halted = 1'b1;
         default: ;
      endcase
   end

   // reset must silence the datapath immediately, not at the next edge
   assign ctl_out = reset_n ? ctl : '0;

   assign pc_write      = ctl_out.pc_write;
   assign pc_write_cond = ctl_out.pc_write_cond;
   assign ir_write      = ctl_out.ir_write;
   assign i_or_d        = ctl_out.i_or_d;
   assign mem_read      = ctl_out.mem_read;
   assign mem_write     = ctl_out.mem_write;
   assign reg_write     = ctl_out.reg_write;
   assign reg_dst       = ctl_out.reg_dst;
   assign mem_to_reg    = ctl_out.mem_to_reg;
   assign alu_src_a     = ctl_out.alu_src_a;
   assign alu_src_b     = ctl_out.alu_src_b;
   assign pc_source     = ctl_out.pc_source;
   assign alu_op        = ctl_out.alu_op;
   assign branch_type   = ctl_out.branch_type;
   assign wwd_valid     = ctl_out.wwd_valid;
   assign halted        = ctl_out.halted;
   assign illegal       = ctl_out.illegal;

`ifdef MCU_PERF_CNT_EN
   logic             retire;
   logic [CNT_W-1:0] cnt_q;

   // retire = last state of an instruction leaving for IF, or entering HALT
   assign retire = ((state_d == S_IF) && (state_q != S_IF)) ||
                   ((state_d == S_HALT) && (state_q != S_HALT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    cnt_q <= '0;
      else if (retire) cnt_q <= cnt_q + CNT_W'(1);
   end

   assign num_inst = cnt_q;
`endif

endmodule
